mem_sync_ram: RTL and testbench

Parametrised single-port synchronous RAM with self-initialisation, registered read with a valid strobe, write-first collision behaviour and out-of-range address detection. It replaces the fixed 3-bit × 32-entry memory as the general storage primitive for register files, small lookup tables and scratch buffers. After reset it zero-fills itself and signals `busy` until the contents are defined.

---
 rtl/mem_sync_ram.sv | 164 ++++++++++++++++
 tb/tb_mem_sync_ram.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sync_ram.sv
// mem_sync_ram
//   Single-port synchronous RAM with self zero-fill after reset or on request,
//   registered read data with a valid strobe, write-first read/write collision
//   and out-of-range address flagging.
//
// Parameters
//   DATA_W  word width in bits
//   ADDR_W  address width in bits
//   DEPTH   implemented words, 1 <= DEPTH <= 2**ADDR_W
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   clear_req  start a full zero-fill (honoured only when idle)
//   write      write strobe
//   read       read strobe
//   addr       shared read/write word address
//   data_in    write data
//   data_out   registered read data, holds between reads
//   rd_valid   one-cycle pulse when data_out was loaded by a read
//   busy       high while zero-filling; commands are dropped
//   err        one-cycle pulse when the last command had addr >= DEPTH
module mem_sync_ram #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    // Index width that exactly covers DEPTH entries (at least one bit).
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit FULL  = (DEPTH == (1 << ADDR_W));

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                rd_valid_q, rd_valid_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                in_range;
    logic [IDX_W-1:0]    addr_idx;

    assign addr_idx = addr[IDX_W-1:0];

    // A fully populated address space can never be out of range, so err
    // is structurally tied off in that case.
    generate
        if (FULL) begin : g_full
            assign in_range = 1'b1;
        end else begin : g_part
            assign in_range = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        busy_d     = busy_q;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = clr_cnt_q[IDX_W-1:0];
        mem_wdata  = '0;

        case (state_q)
            ST_CLEAR: begin
                // One word zeroed per edge; all commands dropped meanwhile.
                mem_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    clr_cnt_d = '0;
                end
            end

            ST_IDLE: begin
                if (clear_req) begin
                    // Clear wins over any read/write on the same edge.
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    busy_d    = 1'b1;
                end else begin
                    if (write && in_range) begin
                        mem_we    = 1'b1;
                        mem_waddr = addr_idx;
                        mem_wdata = data_in;
                    end
                    if (read) begin
                        rd_valid_d = 1'b1;
                        // Write-first: a same-edge write forwards its data.
                        if (!in_range)
                            data_out_d = '0;
                        else if (write)
                            data_out_d = data_in;
                        else
                            data_out_d = mem[addr_idx];
                    end
                    err_d = (read || write) && !in_range;
                end
            end

            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
                busy_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Array has no reset; its contents are defined by the zero-fill.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_sync_ram.sv
module tb_mem_sync_ram;

    logic       clk;
    logic       reset;
    logic       clear_req;
    logic       write;
    logic       read;
    logic [4:0] addr;
    logic [2:0] data_in;

    logic [2:0] dout_a, dout_b;
    logic       vld_a, vld_b, busy_a, busy_b, err_a, err_b;

    int checks   = 0;
    int failures = 0;

    // Full-depth instance (3/5/32) and a partially populated one (DEPTH=24)
    // driven by the same stimulus.
    mem_sync_ram #(.DATA_W(3), .ADDR_W(5), .DEPTH(32)) dut_a (
        .clk(clk), .reset(reset), .clear_req(clear_req), .write(write),
        .read(read), .addr(addr), .data_in(data_in), .data_out(dout_a),
        .rd_valid(vld_a), .busy(busy_a), .err(err_a)
    );

    mem_sync_ram #(.DATA_W(3), .ADDR_W(5), .DEPTH(24)) dut_b (
        .clk(clk), .reset(reset), .clear_req(clear_req), .write(write),
        .read(read), .addr(addr), .data_in(data_in), .data_out(dout_b),
        .rd_valid(vld_b), .busy(busy_b), .err(err_b)
    );

    // Posedges at 10, 20, ...; reset released at t=5 between edges.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int na, nb;
        reset = 1'b1; clear_req = 1'b0; write = 1'b0; read = 1'b0;
        addr = '0; data_in = '0;
        #1 reset = 1'b0;
        #2;
        checks++;
        if ({busy_a, vld_a, err_a, dout_a} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_outputs got busy/vld/err/data=%b exp=100000",
                     {busy_a, vld_a, err_a, dout_a});
        end
        #2 reset = 1'b1;
        na = 0; nb = 0;
        for (int e = 1; e <= 40; e++) begin
            tick;
            if (!busy_b && nb == 0) nb = e;
            if (!busy_a) begin na = e; break; end
        end
        checks++;
        if (na != 32) begin
            failures++;
            $display("FAIL fill_busy_edges depth32 got=%0d exp=32", na);
        end
        checks++;
        if (nb != 24) begin
            failures++;
            $display("FAIL fill_busy_edges depth24 got=%0d exp=24", nb);
        end
    endtask

    task automatic test_zero_fill;
        for (int i = 0; i < 32; i++) begin
            read = 1'b1; addr = 5'(i);
            tick;
            checks++;
            if (dout_a !== 3'b000 || vld_a !== 1'b1) begin
                failures++;
                $display("FAIL zero_read[%0d] got data=%b vld=%b exp data=000 vld=1",
                         i, dout_a, vld_a);
            end
        end
        read = 1'b0;
    endtask

    task automatic test_write_read;
        write = 1'b1; addr = 5'd3; data_in = 3'b110; tick;
        addr = 5'd4; data_in = 3'b101; tick;
        write = 1'b0; read = 1'b1; addr = 5'd3; tick;
        checks++;
        if (dout_a !== 3'b110 || vld_a !== 1'b1) begin
            failures++;
            $display("FAIL read_addr3 got data=%b vld=%b exp data=110 vld=1", dout_a, vld_a);
        end
        addr = 5'd4; tick;
        checks++;
        if (dout_a !== 3'b101 || vld_a !== 1'b1) begin
            failures++;
            $display("FAIL read_addr4 got data=%b vld=%b exp data=101 vld=1", dout_a, vld_a);
        end
        read = 1'b0; tick;
        checks++;
        if (dout_a !== 3'b101 || vld_a !== 1'b0) begin
            failures++;
            $display("FAIL read_hold got data=%b vld=%b exp data=101 vld=0", dout_a, vld_a);
        end
        tick;
        checks++;
        if (dout_a !== 3'b101 || vld_a !== 1'b0) begin
            failures++;
            $display("FAIL read_hold2 got data=%b vld=%b exp data=101 vld=0", dout_a, vld_a);
        end
    endtask

    task automatic test_collision;
        write = 1'b1; read = 1'b1; addr = 5'd7; data_in = 3'b011; tick;
        checks++;
        if (dout_a !== 3'b011 || vld_a !== 1'b1) begin
            failures++;
            $display("FAIL collision_write_first got data=%b vld=%b exp data=011 vld=1",
                     dout_a, vld_a);
        end
        write = 1'b0; data_in = 3'b000; tick;
        checks++;
        if (dout_a !== 3'b011 || vld_a !== 1'b1) begin
            failures++;
            $display("FAIL collision_stored got data=%b vld=%b exp data=011 vld=1",
                     dout_a, vld_a);
        end
        read = 1'b0;
    endtask

    task automatic test_out_of_range;
        logic [2:0] exp;
        write = 1'b1; addr = 5'd25; data_in = 3'b111; tick;
        checks++;
        if (err_b !== 1'b1 || vld_b !== 1'b0) begin
            failures++;
            $display("FAIL oob_write_err got err=%b vld=%b exp err=1 vld=0", err_b, vld_b);
        end
        checks++;
        if (err_a !== 1'b0) begin
            failures++;
            $display("FAIL full_depth_no_err got err=%b exp=0", err_a);
        end
        write = 1'b0; read = 1'b1; tick;
        checks++;
        if (err_b !== 1'b1 || vld_b !== 1'b1 || dout_b !== 3'b000) begin
            failures++;
            $display("FAIL oob_read got err=%b vld=%b data=%b exp err=1 vld=1 data=000",
                     err_b, vld_b, dout_b);
        end
        checks++;
        if (dout_a !== 3'b111 || err_a !== 1'b0) begin
            failures++;
            $display("FAIL full_depth_addr25 got data=%b err=%b exp data=111 err=0",
                     dout_a, err_a);
        end
        read = 1'b0; tick;
        checks++;
        if (err_b !== 1'b0) begin
            failures++;
            $display("FAIL oob_err_pulse got err=%b exp=0", err_b);
        end
        for (int i = 0; i < 24; i++) begin
            exp = (i == 3) ? 3'b110 : (i == 4) ? 3'b101 : (i == 7) ? 3'b011 : 3'b000;
            read = 1'b1; addr = 5'(i); tick;
            checks++;
            if (dout_b !== exp || vld_b !== 1'b1 || err_b !== 1'b0) begin
                failures++;
                $display("FAIL depth24_contents[%0d] got data=%b vld=%b err=%b exp data=%b vld=1 err=0",
                         i, dout_b, vld_b, err_b, exp);
            end
        end
        read = 1'b0;
    endtask

    task automatic test_clear;
        int n;
        write = 1'b1; addr = 5'd9; data_in = 3'b010; tick;
        write = 1'b0; clear_req = 1'b1; read = 1'b1; tick;
        checks++;
        if (vld_a !== 1'b0 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL clear_priority got vld=%b busy=%b exp vld=0 busy=1", vld_a, busy_a);
        end
        clear_req = 1'b0; read = 1'b0;
        n = 0;
        for (int j = 1; j <= 50; j++) begin
            tick;
            if (!busy_a) begin n = j; break; end
        end
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL clear_busy_edges got=%0d exp=32", n);
        end
        read = 1'b1; addr = 5'd9; tick;
        checks++;
        if (dout_a !== 3'b000 || vld_a !== 1'b1) begin
            failures++;
            $display("FAIL read_after_clear got data=%b vld=%b exp data=000 vld=1", dout_a, vld_a);
        end
        read = 1'b0;
    endtask

    task automatic test_reset_mid;
        int n;
        bit bad;
        // Leave non-reset values on the outputs first.
        write = 1'b1; addr = 5'd25; data_in = 3'b111; tick;
        write = 1'b0; read = 1'b1; tick;
        checks++;
        if (dout_a !== 3'b111 || vld_a !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_read got data=%b vld=%b exp data=111 vld=1", dout_a, vld_a);
        end
        read = 1'b0;
        reset = 1'b0;
        #2;
        checks++;
        if ({busy_a, vld_a, err_a, dout_a} !== 6'b100000) begin
            failures++;
            $display("FAIL async_reset got busy/vld/err/data=%b exp=100000",
                     {busy_a, vld_a, err_a, dout_a});
        end
        #2 reset = 1'b1;
        for (int e = 1; e <= 10; e++) tick;
        checks++;
        if (busy_a !== 1'b1) begin
            failures++;
            $display("FAIL midfill_busy got=%b exp=1", busy_a);
        end
        // Reset during the fill, with a read pending that must not surface.
        reset = 1'b0; read = 1'b1; addr = 5'd3;
        for (int c = 0; c < 2; c++) begin
            tick;
            checks++;
            if ({busy_a, vld_a, err_a, dout_a} !== 6'b100000) begin
                failures++;
                $display("FAIL reset_hold[%0d] got busy/vld/err/data=%b exp=100000",
                         c, {busy_a, vld_a, err_a, dout_a});
            end
        end
        #3;
        reset = 1'b1;
        // Commands during the refill must be ignored.
        read = 1'b1; write = 1'b1; addr = 5'd5; data_in = 3'b111;
        n = 0; bad = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick;
            if (vld_a || err_a) bad = 1'b1;
            if (!busy_a) begin n = e; break; end
        end
        read = 1'b0; write = 1'b0;
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL refill_busy_edges got=%0d exp=32", n);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL refill_ignores_cmds got vld_or_err=1 exp=0");
        end
        read = 1'b1; addr = 5'd5; tick;
        checks++;
        if (dout_a !== 3'b000 || vld_a !== 1'b1) begin
            failures++;
            $display("FAIL read_after_refill got data=%b vld=%b exp data=000 vld=1", dout_a, vld_a);
        end
        read = 1'b0;
    endtask

    initial begin
        test_reset;
        test_zero_fill;
        test_write_read;
        test_collision;
        test_out_of_range;
        test_clear;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
